sum_unit_arbiter: RTL

//  Shares one SUM_unit (28-bit CLA adder) between NUM_REQ requesters in the FP ALU.
//  - Round-robin arbitration over per-requester valid/ready operand ports.
//  - 2-stage pipeline (operand reg -> adder -> result reg); result returned with requester ID.
//  - Sits between mantissa align/normalise/round clients and the single shared adder instance.

---
 rtl/sum_unit_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sum_unit_arbiter.sv
// -----------------------------------------------------------------------------
// sum_unit_arbiter
//   Shares one SIZE_SUM-bit adder between NUM_REQ requesters of the FP ALU
//   (mantissa align / normalise / round clients). Requests are picked
//   round-robin. Each op then passes through a 2-stage pipeline: the operand
//   register feeds the combinational adder, and the sum lands in the result
//   register. Every result is tagged with the ID of the requester that issued it.
//
// Ports
//   i_clk         clock; all state changes on the rising edge
//   i_rst         synchronous reset, active-high
//   i_req_valid   per-requester operand valid
//   o_req_ready   per-requester accept; at most one bit set (combinational)
//   i_req_data_a  operand A, requester k at [k*SIZE_SUM +: SIZE_SUM]
//   i_req_data_b  operand B, same packing
//   i_req_carry   carry-in per requester
//   o_rsp_valid   result valid
//   i_rsp_ready   result consumer ready
//   o_rsp_sum     A+B+cin mod 2^SIZE_SUM
//   o_rsp_carry   adder carry-out
//   o_rsp_id      index of the requester that issued this result
// -----------------------------------------------------------------------------
module sum_unit_arbiter #(
  parameter  int SIZE_SUM = 28,
  parameter  int NUM_REQ  = 4,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  output logic [NUM_REQ-1:0]           o_req_ready,
  input  logic [NUM_REQ*SIZE_SUM-1:0]  i_req_data_a,
  input  logic [NUM_REQ*SIZE_SUM-1:0]  i_req_data_b,
  input  logic [NUM_REQ-1:0]           i_req_carry,
  output logic                         o_rsp_valid,
  input  logic                         i_rsp_ready,
  output logic [SIZE_SUM-1:0]          o_rsp_sum,
  output logic                         o_rsp_carry,
  output logic [ID_W-1:0]              o_rsp_id
);

  // Shared adder in generate/propagate form; returns {carry_out, sum}.
  function automatic logic [SIZE_SUM:0] sum_unit(input logic [SIZE_SUM-1:0] a,
                                                 input logic [SIZE_SUM-1:0] b,
                                                 input logic                cin);
    logic [SIZE_SUM-1:0] g;
    logic [SIZE_SUM-1:0] p;
    logic [SIZE_SUM:0]   c;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SIZE_SUM; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[SIZE_SUM], p ^ c[SIZE_SUM-1:0]};
  endfunction

  // Operand stage
  logic                op_vld;
  logic [SIZE_SUM-1:0] op_a;
  logic [SIZE_SUM-1:0] op_b;
  logic                op_cin;
  logic [ID_W-1:0]     op_id;

  // Result stage
  logic                rsp_vld;
  logic [SIZE_SUM-1:0] rsp_sum;
  logic                rsp_carry;
  logic [ID_W-1:0]     rsp_id;

  logic [ID_W-1:0]     rr_ptr;

  // Arbitration / handshake
  logic                rsp_adv;
  logic                op_adv;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic                found;
  logic                accept;
  logic [ID_W-1:0]     next_ptr;
  logic [SIZE_SUM-1:0] sel_a;
  logic [SIZE_SUM-1:0] sel_b;
  logic                sel_cin;
  logic [SIZE_SUM:0]   add_res;

  // The result register frees up when it is empty or being popped. The op
  // register may accept new work whenever its content can move forward.
  assign rsp_adv = ~rsp_vld | i_rsp_ready;
  assign op_adv  = ~op_vld | rsp_adv;

  // Round-robin search: first valid requester at or after rr_ptr, with wrap.
  always_comb begin
    int idx;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && i_req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // Ready is low throughout reset and whenever the op register cannot advance.
  assign o_req_ready = (op_adv && !i_rst) ? grant : '0;
  assign accept      = |o_req_ready;
  assign next_ptr    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  // Operand mux for the winning requester.
  always_comb begin
    sel_a   = i_req_data_a[int'(grant_id)*SIZE_SUM +: SIZE_SUM];
    sel_b   = i_req_data_b[int'(grant_id)*SIZE_SUM +: SIZE_SUM];
    sel_cin = i_req_carry[grant_id];
  end

  assign add_res = sum_unit(op_a, op_b, op_cin);

  // Pipeline registers, occupancy and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_vld    <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      op_id     <= '0;
      rsp_vld   <= 1'b0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      // Result stage: take the op register's result, or drain to empty.
      if (rsp_adv) begin
        rsp_vld <= op_vld;
        if (op_vld) begin
          rsp_sum   <= add_res[SIZE_SUM-1:0];
          rsp_carry <= add_res[SIZE_SUM];
          rsp_id    <= op_id;
        end
      end
      // Operand stage: capture the granted request; with no grant it empties,
      // because op_adv together with op_vld implies the content moved on.
      if (op_adv) begin
        op_vld <= accept;
        if (accept) begin
          op_a   <= sel_a;
          op_b   <= sel_b;
          op_cin <= sel_cin;
          op_id  <= grant_id;
          rr_ptr <= next_ptr;
        end
      end
    end
  end

  assign o_rsp_valid = rsp_vld;
  assign o_rsp_sum   = rsp_sum;
  assign o_rsp_carry = rsp_carry;
  assign o_rsp_id    = rsp_id;

endmodule
